// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC Wishbone interconnect: arbiter state
// encoding, master indices and the default watchdog limit.
`default_nettype none

package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic IBUS = 1'b0;
  localparam logic DBUS = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

`default_nettype wire

// File: rtl/wb_bus_watchdog.sv
// Bus-timeout watchdog: counts granted cycles without a response and flags
// the TIMEOUT_CYCLES-th one.
`default_nettype none

module wb_bus_watchdog
  import soc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TW             = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Gated by en so a response arriving on the limit cycle wins over the timeout.
  assign hit_o = en_i && (count_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/wb_cpu_bus_arbiter.sv
// Two-master round-robin Wishbone B4 arbiter (ibus = m0, dbus = m1) onto one
// slave port, one transfer per grant, with a watchdog forcing err on hangs.
`default_nettype none

module wb_cpu_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TW             = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_dat_i,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dat_o,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_dat_i,
  output logic [31:0] s_addr,
  output logic [31:0] s_dat_o,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic        s_cyc,
  output logic        s_stb,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic [31:0] s_dat_i,
  output logic        timeout_o,
  output logic        busy_o
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       req0, req1;
  logic       wd_clr, wd_en, timeout_hit;
  logic       s_req;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  assign busy_o    = (state_q != IDLE);
  assign wd_en     = busy_o & ~s_ack & ~s_err;
  assign wd_clr    = (state_q == IDLE) && (state_d != IDLE);
  assign timeout_o = timeout_hit;
  assign m0_dat_i  = s_dat_i;
  assign m1_dat_i  = s_dat_i;
  assign s_cyc     = s_req;
  assign s_stb     = s_req;

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .hit_o (timeout_hit)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s_addr       = '0;
    s_dat_o      = '0;
    s_we         = 1'b0;
    s_sel        = 4'h0;
    s_req        = 1'b0;
    m0_ack       = 1'b0;
    m0_err       = 1'b0;
    m1_ack       = 1'b0;
    m1_err       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Round-robin tie-break: prefer the master that did not hold the last grant.
        if (req0 && (!req1 || last_grant_q == DBUS)) begin
          state_d      = GNT0;
          last_grant_d = IBUS;
        end else if (req1) begin
          state_d      = GNT1;
          last_grant_d = DBUS;
        end
      end
      GNT0: begin
        s_addr = m0_addr;
        s_sel  = 4'hF;
        s_req  = req0 & ~timeout_hit;
        m0_ack = s_ack & ~s_err;
        m0_err = s_err | timeout_hit;
        if (s_ack || s_err || timeout_hit || !m0_cyc) state_d = IDLE;
      end
      GNT1: begin
        s_addr  = m1_addr;
        s_dat_o = m1_dat_o;
        s_we    = m1_we;
        s_sel   = m1_sel;
        s_req   = req1 & ~timeout_hit;
        m1_ack  = s_ack & ~s_err;
        m1_err  = s_err | timeout_hit;
        if (s_ack || s_err || timeout_hit || !m1_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= DBUS;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire
